// File: rtl/relu_backward_unit.sv
// ReLU backward pass: captures a forward matrix as a strictly-positive mask, then
// gates incoming gradient matrices with that mask, Lanes elements per cycle.
module relu_backward_unit #(
   parameter int Row_Limit = 10,
   parameter int Lanes     = 10
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             fwd_valid,
   output logic                             fwd_ready,
   input  logic [5*Row_Limit*Row_Limit-1:0] fwd_matrix,
   input  logic                             grad_valid,
   output logic                             grad_ready,
   input  logic [5*Row_Limit*Row_Limit-1:0] grad_matrix,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [5*Row_Limit*Row_Limit-1:0] out_matrix,
   output logic                             mask_valid,
   output logic                             busy
);

   localparam int NN = Row_Limit * Row_Limit;
   localparam int NC = (NN + Lanes - 1) / Lanes;
   localparam int CW = (NC > 1) ? $clog2(NC) : 1;
   localparam logic [CW-1:0] LAST_CHUNK = CW'(NC - 1);

   typedef enum logic [1:0] {
      IDLE,
      PROC,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [NN-1:0]   mask_q, mask_d;
   logic            mask_valid_q, mask_valid_d;
   logic [CW-1:0]   chunk_q, chunk_d;
   logic [5*NN-1:0] work_q, work_d;
   logic [5*NN-1:0] out_q, out_d;
   logic            out_valid_q, out_valid_d;

   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      mask_valid_d = mask_valid_q;
      chunk_d      = chunk_q;
      work_d       = work_q;
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      unique case (state_q)
         IDLE: begin
            // A forward load pre-empts any pending gradient in the same cycle
            if (fwd_valid) begin
               for (int i = 0; i < NN; i++) begin
                  mask_d[i] = !fwd_matrix[4*NN+i] &&
                              (fwd_matrix[3*NN+i] || fwd_matrix[2*NN+i] ||
                               fwd_matrix[NN+i]   || fwd_matrix[i]);
               end
               mask_valid_d = 1'b1;
            end else if (grad_valid && mask_valid_q) begin
               work_d  = grad_matrix;
               chunk_d = '0;
               state_d = PROC;
            end
         end
         PROC: begin
            for (int i = 0; i < NN; i++) begin
               if (CW'(i / Lanes) == chunk_q) begin
                  for (int k = 0; k < 5; k++) begin
                     out_d[k*NN+i] = mask_q[i] & work_q[k*NN+i];
                  end
               end
            end
            if (chunk_q == LAST_CHUNK) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
            end else begin
               chunk_d = chunk_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         mask_q       <= '0;
         mask_valid_q <= 1'b0;
         chunk_q      <= '0;
         work_q       <= '0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         mask_valid_q <= mask_valid_d;
         chunk_q      <= chunk_d;
         work_q       <= work_d;
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign fwd_ready  = (state_q == IDLE);
   assign grad_ready = (state_q == IDLE) && mask_valid_q && !fwd_valid;
   assign busy       = (state_q != IDLE);
   assign out_valid  = out_valid_q;
   assign out_matrix = out_q;
   assign mask_valid = mask_valid_q;

endmodule

// File: tb/tb_relu_backward_unit.sv
// Bench for relu_backward_unit: a 2x2/Lanes=3 instance and a default 10x10 instance,
// both checked every cycle against an element-level model, plus literal expectations.
module tb_relu_backward_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         fv[2], gv[2], ordy[2];
   logic [499:0] fbus[2], gbus[2];
   logic         fr[2], gr[2], ov[2], mv[2], bz[2];
   logic [499:0] obus[2];

   logic        s_fr, s_gr, s_ov, s_mv, s_bz;
   logic [19:0] s_out;
   logic        d_fr, d_gr, d_ov, d_mv, d_bz;
   logic [499:0] d_out;

   relu_backward_unit #(.Row_Limit(2), .Lanes(3)) u_small (
      .clk(clk), .rst(rst),
      .fwd_valid(fv[0]), .fwd_ready(s_fr), .fwd_matrix(fbus[0][19:0]),
      .grad_valid(gv[0]), .grad_ready(s_gr), .grad_matrix(gbus[0][19:0]),
      .out_valid(s_ov), .out_ready(ordy[0]), .out_matrix(s_out),
      .mask_valid(s_mv), .busy(s_bz)
   );

   relu_backward_unit u_dflt (
      .clk(clk), .rst(rst),
      .fwd_valid(fv[1]), .fwd_ready(d_fr), .fwd_matrix(fbus[1]),
      .grad_valid(gv[1]), .grad_ready(d_gr), .grad_matrix(gbus[1]),
      .out_valid(d_ov), .out_ready(ordy[1]), .out_matrix(d_out),
      .mask_valid(d_mv), .busy(d_bz)
   );

   assign fr[0] = s_fr;  assign fr[1] = d_fr;
   assign gr[0] = s_gr;  assign gr[1] = d_gr;
   assign ov[0] = s_ov;  assign ov[1] = d_ov;
   assign mv[0] = s_mv;  assign mv[1] = d_mv;
   assign bz[0] = s_bz;  assign bz[1] = d_bz;
   assign obus[0] = {480'b0, s_out};
   assign obus[1] = d_out;

   // reference model state, per instance
   bit           mask_m[2][100];
   bit           mval_m[2];
   int           remain_m[2];
   bit           oval_m[2];
   logic [4:0]   work_m[2][100];
   logic [499:0] exp_m[2];

   int total = 0;
   int bad   = 0;

   function automatic int nn_of(input int k);
      return (k == 0) ? 4 : 100;
   endfunction

   function automatic int chunks_of(input int k);
      return (k == 0) ? 2 : 10;  // ceil(4/3), ceil(100/10)
   endfunction

   function automatic logic [4:0] elem(input logic [499:0] b, input int n, input int i);
      logic [4:0] v;
      for (int k = 0; k < 5; k++) v[k] = b[k*n+i];
      return v;
   endfunction

   function automatic logic [499:0] pack_all(input logic [4:0] v, input int n);
      logic [499:0] b = '0;
      for (int i = 0; i < n; i++)
         for (int k = 0; k < 5; k++) b[k*n+i] = v[k];
      return b;
   endfunction

   function automatic logic [499:0] pack4(input logic [4:0] a, input logic [4:0] b,
                                          input logic [4:0] c, input logic [4:0] d);
      logic [499:0] r = '0;
      logic [4:0]   e[4];
      e[0] = a; e[1] = b; e[2] = c; e[3] = d;
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 5; k++) r[k*4+i] = e[i][k];
      return r;
   endfunction

   function automatic logic [499:0] rnd_bus();
      logic [499:0] b;
      for (int i = 0; i < 500; i++) b[i] = 1'($urandom);
      return b;
   endfunction

   task automatic report(input string nm, input string act, input string exp);
      bad++;
      $display("FAIL %s got=%s want=%s", nm, act, exp);
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) report(nm, $sformatf("%b", act), $sformatf("%b", exp));
   endtask

   task automatic chkv(input string nm, input logic [499:0] act, input logic [499:0] exp);
      total++;
      if (act !== exp) report(nm, $sformatf("%h", act), $sformatf("%h", exp));
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      total++;
      if (act != exp) report(nm, $sformatf("%0d", act), $sformatf("%0d", exp));
   endtask

   task automatic model_reset(input int k);
      for (int i = 0; i < 100; i++) begin
         mask_m[k][i] = 1'b0;
         work_m[k][i] = '0;
      end
      mval_m[k]   = 1'b0;
      remain_m[k] = 0;
      oval_m[k]   = 1'b0;
      exp_m[k]    = '0;
   endtask

   task automatic model_step(input int k);
      int n = nn_of(k);
      if (rst) begin
         model_reset(k);
      end else if (remain_m[k] == 0 && !oval_m[k]) begin
         if (fv[k]) begin
            for (int i = 0; i < n; i++) mask_m[k][i] = ($signed(elem(fbus[k], n, i)) > 5'sd0);
            mval_m[k] = 1'b1;
         end else if (gv[k] && mval_m[k]) begin
            for (int i = 0; i < n; i++) work_m[k][i] = elem(gbus[k], n, i);
            remain_m[k] = chunks_of(k);
         end
      end else if (remain_m[k] > 0) begin
         remain_m[k]--;
         if (remain_m[k] == 0) begin
            exp_m[k] = '0;
            for (int i = 0; i < n; i++)
               for (int b = 0; b < 5; b++)
                  exp_m[k][b*n+i] = mask_m[k][i] ? work_m[k][i][b] : 1'b0;
            oval_m[k] = 1'b1;
         end
      end else if (ordy[k]) begin
         oval_m[k] = 1'b0;
      end
   endtask

   task automatic compare(input int k);
      bit    idle = (remain_m[k] == 0) && !oval_m[k];
      string p    = (k == 0) ? "small" : "dflt";
      chkb({p, "_out_valid"},  ov[k], oval_m[k]);
      chkb({p, "_fwd_ready"},  fr[k], idle);
      chkb({p, "_grad_ready"}, gr[k], idle && mval_m[k] && !fv[k]);
      chkb({p, "_busy"},       bz[k], !idle);
      chkb({p, "_mask_valid"}, mv[k], mval_m[k]);
      if (remain_m[k] == 0) chkv({p, "_out_matrix"}, obus[k], exp_m[k]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      compare(0);
      compare(1);
   endtask

   task automatic wait_ov(input int k, input int budget, output int n);
      n = 0;
      while (!ov[k] && n < budget) begin
         tick();
         n++;
      end
      if (!ov[k]) begin
         total++;
         report("wait_out_valid_timeout", "0", "1");
      end
   endtask

   initial begin
      int lat;
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         fv[k] = 1'b0; gv[k] = 1'b0; ordy[k] = 1'b0;
         fbus[k] = '0; gbus[k] = '0;
         model_reset(k);
      end
      tick();
      chkb("reset_mask_valid", d_mv, 1'b0);
      chkb("reset_out_valid", d_ov, 1'b0);
      chkv("reset_out_matrix", d_out, 500'b0);
      rst = 1'b0;
      tick();

      // small instance: partial last chunk
      fbus[0] = pack4(5'b11101, 5'b00000, 5'b00101, 5'b10000);
      fv[0] = 1'b1;
      tick();
      fv[0] = 1'b0;
      chkb("small_mask_valid", s_mv, 1'b1);
      gbus[0] = pack4(5'b00111, 5'b00111, 5'b11111, 5'b01001);
      gv[0] = 1'b1;
      tick();
      gv[0] = 1'b0;
      wait_ov(0, 20, lat);
      chki("small_latency", lat, 2);
      chkv("small_out", obus[0], 500'(20'h44444));
      ordy[0] = 1'b1;
      tick();

      // default instance: all +1 mask, all-ones grad, with backpressure
      fbus[1] = pack_all(5'b00001, 100);
      fv[1] = 1'b1;
      tick();
      fv[1] = 1'b0;
      gbus[1] = pack_all(5'b11111, 100);
      gv[1] = 1'b1;
      tick();
      gv[1] = 1'b0;
      wait_ov(1, 40, lat);
      chki("dflt_latency", lat, 10);
      chkv("dflt_out_ones", d_out, {500{1'b1}});
      repeat (5) begin
         tick();
         chkb("bp_out_valid", d_ov, 1'b1);
         chkb("bp_busy", d_bz, 1'b1);
         chkb("bp_grad_ready", d_gr, 1'b0);
         chkv("bp_out_hold", d_out, {500{1'b1}});
      end
      ordy[1] = 1'b1;
      tick();
      chkb("bp_release_idle", d_fr, 1'b1);

      // second grad reuses the mask
      gbus[1] = pack_all(5'b00011, 100);
      gv[1] = 1'b1;
      tick();
      gv[1] = 1'b0;
      ordy[1] = 1'b0;
      wait_ov(1, 40, lat);
      chkv("dflt_out_00011", d_out, {{300{1'b0}}, {200{1'b1}}});
      ordy[1] = 1'b1;
      tick();

      // fwd and grad together: fwd wins, grad follows under the new mask
      fbus[1] = pack_all(5'b11000, 100);
      gbus[1] = pack_all(5'b11111, 100);
      fv[1] = 1'b1;
      gv[1] = 1'b1;
      #1;
      chkb("collide_grad_ready", d_gr, 1'b0);
      tick();
      fv[1] = 1'b0;
      tick();
      gv[1] = 1'b0;
      ordy[1] = 1'b0;
      wait_ov(1, 40, lat);
      chkv("collide_out_zero", d_out, 500'b0);
      ordy[1] = 1'b1;
      tick();

      // randomized traffic on both instances
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < 2; k++) begin
            fv[k]   = ($urandom_range(0, 4) == 0);
            gv[k]   = 1'($urandom);
            ordy[k] = ($urandom_range(0, 2) != 0);
            fbus[k] = rnd_bus();
            gbus[k] = rnd_bus();
         end
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         fv[k] = 1'b0; gv[k] = 1'b0; ordy[k] = 1'b1;
      end
      repeat (15) tick();

      // reset, then grad with no mask loaded
      rst = 1'b1;
      model_reset(0);
      model_reset(1);
      tick();
      rst = 1'b0;
      gv[0] = 1'b1;
      gv[1] = 1'b1;
      repeat (20) tick();
      chkb("nomask_grad_ready", d_gr, 1'b0);
      chkb("nomask_busy", d_bz, 1'b0);
      chkb("nomask_out_valid", d_ov, 1'b0);
      gv[0] = 1'b0;
      gv[1] = 1'b0;

      // reset three cycles into PROC
      fbus[1] = pack_all(5'b00001, 100);
      fv[1] = 1'b1;
      tick();
      fv[1] = 1'b0;
      gbus[1] = pack_all(5'b11111, 100);
      gv[1] = 1'b1;
      tick();
      gv[1] = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      chkb("midrst_out_valid", d_ov, 1'b0);
      chkv("midrst_out_matrix", d_out, 500'b0);
      chkb("midrst_mask_valid", d_mv, 1'b0);
      model_reset(0);
      model_reset(1);
      tick();
      rst = 1'b0;
      gv[1] = 1'b1;
      repeat (5) tick();
      chkb("midrst_grad_ready", d_gr, 1'b0);
      gv[1] = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/relu_backward_unit.md
Name: relu_backward_unit

Overview:
- Backward (gradient) pass for the ReLU stage in the fuzzy/NN matrix pipeline.
- Captures a forward-pass input matrix as a per-element pass mask, then gates incoming gradient matrices with that mask.
- Matrices use the codebase's bit-plane packed 5-bit two's-complement format; plane 4 is the sign plane.
- Gating is processed Lanes elements per cycle, with valid/ready handshakes on input and output.

Parameters:
- Row_Limit, 10, matrix is Row_Limit x Row_Limit; NN = Row_Limit*Row_Limit elements.
- Lanes, 10, elements gated per PROC cycle; legal range 1..NN; need not divide NN.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- fwd_valid  input  1  fwd_matrix valid.
- fwd_ready  output  1  = (state==IDLE).
- fwd_matrix  input  5*NN  forward activation input, bit-plane packed.
- grad_valid  input  1  grad_matrix valid.
- grad_ready  output  1  = (state==IDLE) && mask_valid && !fwd_valid.
- grad_matrix  input  5*NN  upstream gradient, bit-plane packed.
- out_valid  output  1  out_matrix holds a completed result.
- out_ready  input  1  downstream accepts the result.
- out_matrix  output  5*NN  gated gradient, bit-plane packed.
- mask_valid  output  1  a mask has been loaded since reset.
- busy  output  1  = (state!=IDLE).

Behaviour:
- Packing: element i (0..NN-1) bit k lives at bus[k*NN+i]; the value is {bus[4NN+i], bus[3NN+i], bus[2NN+i], bus[NN+i], bus[i]}.
- Reset (async, immediate on rst rise):
  - state=IDLE, out_valid=0, out_matrix=0, mask=0, mask_valid=0, chunk counter=0, working register=0.
- States: IDLE, PROC, DONE.
- Mask load (IDLE, fwd_valid&&fwd_ready):
  - mask[i] = 1 iff element i is strictly positive (sign bit 0 and any lower bit 1).
  - mask_valid=1 from the next cycle. State stays IDLE.
  - Zero and negative elements give mask 0.
- Priority: fwd_valid in IDLE always wins; grad_ready is low that cycle, so a grad is never gated by a half-updated mask.
- Grad accept (IDLE, grad_valid&&grad_ready):
  - Latch grad_matrix into the working register; chunk counter=0; go to PROC.
- PROC: each cycle gates elements [c*Lanes, min((c+1)*Lanes, NN)-1].
  - Gating writes all 5 planes of out_matrix: grad value if mask[i]=1, else 0.
  - c increments each cycle. The last chunk is c = ceil(NN/Lanes)-1 and may be partial.
  - On the last chunk, go to DONE and set out_valid=1 on the same edge.
- Latency: out_valid rises exactly C = ceil(NN/Lanes) edges after the accept edge.
- DONE:
  - out_matrix and out_valid are held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid=0 and return to IDLE; out_matrix keeps its last value.
- No new fwd or grad is accepted outside IDLE (fwd_ready=grad_ready=0).
- The mask persists across any number of grads until the next fwd load or reset.
- grad_valid with mask_valid=0: grad_ready=0, nothing happens.
- Reset mid-PROC/DONE: operation aborted, no out_valid pulse, all reset values restored.
- out_matrix elements outside the chunks written for the current grad are not read by downstream before out_valid.

Test Plan:
- Row_Limit=2, Lanes=3. Load fwd elements {-3(11101), 0, 5(00101), -16(10000)}, then grad {7, 7, -1(11111), 9}. Required: out_valid exactly 2 cycles after the accept edge, out = {0, 0, 11111, 0}, mask_valid=1.
- Defaults, fwd all +1 and grad all 5'b11111. Required: out_valid 10 cycles after accept, out_matrix all ones. A second grad (all 5'b00011) without a reload gives all 5'b00011.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Required: out_valid=1 and out_matrix constant throughout, fwd_ready=grad_ready=0, busy=1. Raising out_ready gives IDLE the next cycle.
- In IDLE with a mask loaded, assert fwd_valid and grad_valid together (new fwd all negative). Required: grad_ready=0 that cycle and the mask reloads. The grad is accepted the next cycle and out = all zeros.
- After reset, grad_valid=1 with no fwd load. Required: grad_ready=0 indefinitely, busy=0, out_valid never rises.
- Assert rst 3 cycles into PROC (defaults). Required: out_valid=0, out_matrix=0, mask_valid=0 immediately. After release, grad_ready=0 until a new fwd load.
